// File: rtl/core_pkg.sv
// Shared core constants plus the OBI responder state type.
// DATA_WIDTH, ADDR_WIDTH, BYTE_LENGTH and ADDR_OFFSET_WIDTH are the core-wide bus constants.
package core_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int ADDR_WIDTH        = 32;
  localparam int BYTE_LENGTH       = 8;
  localparam int ADDR_OFFSET_WIDTH = 2;
  localparam int OBI_MAX_WAIT      = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } obi_rsp_state_e;

  // Byte-offset bits of an address for a given bus width (2 for 32-bit, 3 for 64-bit).
  function automatic int obi_offset_width(input int data_width);
    return (data_width == 64) ? ADDR_OFFSET_WIDTH + 1 : ADDR_OFFSET_WIDTH;
  endfunction

endpackage

// File: rtl/obi_mem_responder_sram_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
// Memory contents are not reset.
module sram_be
  import core_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  parameter  int DATA_WIDTH  = 32,
  localparam int IDX_W       = $clog2(DEPTH_WORDS),
  localparam int BYTES       = DATA_WIDTH / BYTE_LENGTH
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BYTES-1:0]      be_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BYTES; b++) begin
          if (be_i[b]) begin
            r_mem[addr_i][b*BYTE_LENGTH +: BYTE_LENGTH] <= wdata_i[b*BYTE_LENGTH +: BYTE_LENGTH];
          end
        end
      end else begin
        r_rdata <= r_mem[addr_i];
      end
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/obi_mem_responder.sv
// OBI responder terminating the data-memory port on an internal byte-enabled RAM.
// States: IDLE | no transaction ; WAIT | wait-state countdown ; RESP | rvalid_o pulse, may accept next request
module obi_mem_responder
  import core_pkg::*;
#(
  parameter int                          DATA_WIDTH  = core_pkg::DATA_WIDTH,
  parameter int                          ADDR_WIDTH  = core_pkg::ADDR_WIDTH,
  parameter int                          DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0]       BASE_ADDR   = '0,
  parameter int                          WAIT_CYCLES = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          req_i,
  output logic                          gnt_o,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic                          we_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  input  logic [DATA_WIDTH/8-1:0]       be_i,
  output logic                          rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          err_o
);

  localparam int BYTES = DATA_WIDTH / BYTE_LENGTH;
  localparam int OFFS  = obi_offset_width(DATA_WIDTH);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  obi_rsp_state_e        r_state;
  logic [3:0]            r_cnt;
  logic                  r_rvalid;
  logic                  r_we;
  logic                  r_err;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BYTES-1:0]      r_be;

  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_in_range;
  logic                  w_grant;
  logic                  w_ram_en;
  logic                  w_ram_we;
  logic [IDX_W-1:0]      w_ram_idx;
  logic [DATA_WIDTH-1:0] w_ram_wdata;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic [BYTES-1:0]      w_ram_be;

  // Addresses below BASE_ADDR wrap to a huge word index and fall out of range.
  assign w_word     = (addr_i - BASE_ADDR) >> OFFS;
  assign w_in_range = (w_word < ADDR_WIDTH'(DEPTH_WORDS));

  assign gnt_o   = ~rst_i & req_i & (r_state != WAIT);
  assign w_grant = gnt_o;

  // The RAM is accessed on the edge that enters RESP: straight from the bus with
  // no wait states, otherwise from the captured request on the last WAIT cycle.
  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = we_i;
    w_ram_idx   = w_word[IDX_W-1:0];
    w_ram_wdata = wdata_i;
    w_ram_be    = be_i;
    if (r_state == WAIT) begin
      w_ram_en    = (r_cnt == 4'd1) & ~r_err;
      w_ram_we    = r_we;
      w_ram_idx   = r_idx;
      w_ram_wdata = r_wdata;
      w_ram_be    = r_be;
    end else begin
      w_ram_en = w_grant & w_in_range & (WAIT_CYCLES == 0);
    end
    if (rst_i) begin
      w_ram_en = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_rvalid <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_state)
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state  <= RESP;
            r_rvalid <= 1'b1;
          end
        end
        default: begin
          if (w_grant) begin
            r_we    <= we_i;
            r_err   <= ~w_in_range;
            r_idx   <= w_word[IDX_W-1:0];
            r_wdata <= wdata_i;
            r_be    <= be_i;
            if (WAIT_CYCLES == 0) begin
              r_state  <= RESP;
              r_rvalid <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'(WAIT_CYCLES);
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign rvalid_o = r_rvalid;
  assign err_o    = r_rvalid & r_err;
  assign rdata_o  = (r_rvalid & ~r_err & ~r_we) ? w_ram_rdata : '0;

  sram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (w_ram_en),
    .we_i    (w_ram_we),
    .addr_i  (w_ram_idx),
    .wdata_i (w_ram_wdata),
    .be_i    (w_ram_be),
    .rdata_o (w_ram_rdata)
  );

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench: three responders (0, 3 and 2 wait states) driven by vector tables
// and hand-written sequences for latency, back-to-back and reset corner cases.
module tb_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic        gnt   [3];
  logic        rvalid[3];
  logic        err   [3];
  logic [31:0] rdata [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  obi_mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .wdata_i(wdata[0]), .be_i(be[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  obi_mem_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .wdata_i(wdata[1]), .be_i(be[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  obi_mem_responder #(.WAIT_CYCLES(2)) u_w2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
    .we_i(we[2]), .wdata_i(wdata[2]), .be_i(be[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    req[k]   = r;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    be[k]    = b;
  endtask

  // One transaction with a bounded wait for rvalid; leaves the bench in the response cycle.
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] rd, output logic e);
    logic got;
    got = 1'b0;
    rd  = '0;
    e   = 1'b0;
    tick();
    drive(k, 1'b1, w, a, d, b);
    #1;
    chk($sformatf("txn%0d_gnt", k), 32'(gnt[k]), 32'd1);
    tick();
    drive(k, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 40 && !got; i++) begin
      if (rvalid[k]) begin
        got = 1'b1;
        rd  = rdata[k];
        e   = err[k];
      end else begin
        tick();
      end
    end
    chk($sformatf("txn%0d_rvalid_seen", k), 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'h5, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, 32'h0000_0000};
    vecs[4]  = '{1'b1, 32'h0000_0020, 32'h0000_AA00, 4'h2, 1'b0, 32'h0000_0000};
    vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 1'b0, 32'h1122_AA44};
    vecs[6]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0000_0000};
    vecs[7]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 1'b0, 32'h1122_AA44};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0000_0000};
    vecs[9]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 1'b1, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'hF, 1'b1, 32'h0000_0000};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 1'b0, 32'h0BAD_F00D};
    vecs[12] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0000_0000};
    vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'hF, 1'b0, 32'hCAFE_F00D};
    vecs[14] = '{1'b1, 32'h0000_0024, 32'h0000_0000, 4'hF, 1'b0, 32'h0000_0000};
    vecs[15] = '{1'b1, 32'h0000_0024, 32'hAABB_CCDD, 4'h9, 1'b0, 32'h0000_0000};
    vecs[16] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 4'hF, 1'b0, 32'hAA00_00DD};

    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, '0, '0, '0);

    // Reset held with random traffic: outputs must stay quiet.
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        drive(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              4'($urandom_range(0, 15)));
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst_rvalid%0d", k), 32'(rvalid[k]), 32'd0);
        chk($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
        chk($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
      end
    end
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, '0, '0, '0);
    tick();
    rst = 1'b0;
    #1;
    req[0] = 1'b1;
    #1;
    chk("gnt_follows_req_hi", 32'(gnt[0]), 32'd1);
    req[0] = 1'b0;
    #1;
    chk("gnt_follows_req_lo", 32'(gnt[0]), 32'd0);

    // Zero-wait-state vector table.
    for (int i = 0; i < NV; i++) begin
      tick();
      drive(0, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt[0]), 32'd1);
      tick();
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid[0]), 32'd1);
      chk($sformatf("v%0d_err", i), 32'(err[0]), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_rdata", i), rdata[0], vecs[i].exp_rdata);
      drive(0, 1'b0, 1'b0, '0, '0, '0);
    end

    // Back-to-back write then read of the same word.
    tick();
    drive(0, 1'b1, 1'b1, 32'h40, 32'h600D_CAFE, 4'hF);
    #1;
    chk("b2b_gnt_w", 32'(gnt[0]), 32'd1);
    tick();
    chk("b2b_rvalid_w", 32'(rvalid[0]), 32'd1);
    chk("b2b_rdata_w", rdata[0], 32'd0);
    drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    #1;
    chk("b2b_gnt_r", 32'(gnt[0]), 32'd1);
    tick();
    chk("b2b_rvalid_r", 32'(rvalid[0]), 32'd1);
    chk("b2b_rdata_r", rdata[0], 32'h600D_CAFE);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("b2b_rvalid_end", 32'(rvalid[0]), 32'd0);

    // Three wait states: latency, gnt blocking, address ignored during WAIT, held request.
    txn(1, 1'b1, 32'h10, 32'h1234_5678, 4'hF, rd, e);
    chk("w3_wr10_err", 32'(e), 32'd0);
    txn(1, 1'b1, 32'h14, 32'h1414_1414, 4'hF, rd, e);
    txn(1, 1'b0, 32'h14, 32'h0, 4'h0, rd, e);
    chk("w3_rd14_setup", rd, 32'h1414_1414);
    tick();
    drive(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    chk("w3_gnt_N", 32'(gnt[1]), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      addr[1] = 32'h14;
      #1;
      chk($sformatf("w3_gnt_N+%0d", c), 32'(gnt[1]), 32'd0);
      chk($sformatf("w3_rvalid_N+%0d", c), 32'(rvalid[1]), 32'd0);
    end
    tick();
    chk("w3_rvalid_N+4", 32'(rvalid[1]), 32'd1);
    chk("w3_rdata_N+4", rdata[1], 32'h1234_5678);
    chk("w3_gnt_N+4", 32'(gnt[1]), 32'd1);
    for (int c = 5; c <= 7; c++) begin
      tick();
      req[1] = 1'b0;
      chk($sformatf("w3_rvalid_N+%0d", c), 32'(rvalid[1]), 32'd0);
    end
    tick();
    chk("w3_rvalid_N+8", 32'(rvalid[1]), 32'd1);
    chk("w3_rdata_N+8", rdata[1], 32'h1414_1414);
    drive(1, 1'b0, 1'b0, '0, '0, '0);

    // Two wait states: reset pulse during WAIT drops the pending write.
    txn(2, 1'b1, 32'h30, 32'h0000_00AA, 4'hF, rd, e);
    tick();
    drive(2, 1'b1, 1'b1, 32'h30, 32'h0000_0055, 4'hF);
    #1;
    chk("rstwait_gnt", 32'(gnt[2]), 32'd1);
    tick();
    drive(2, 1'b0, 1'b0, '0, '0, '0);
    #1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("rstwait_rvalid%0d", c), 32'(rvalid[2]), 32'd0);
    end
    txn(2, 1'b0, 32'h30, 32'h0, 4'h0, rd, e);
    chk("rstwait_old_data", rd, 32'h0000_00AA);
    chk("rstwait_err", 32'(e), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/obi_mem_responder.md
# obi_mem_responder

OBI responder (slave) terminating the core data-memory port: accepts address-phase requests (`req`/`gnt`), performs byte-masked writes or word reads on an internal single-port RAM, and returns the response phase (`rvalid`/`rdata`/`err`). It sits between the MEM stage's OBI initiator and on-chip data RAM. Configurable wait states let initiators be exercised against non-ideal latency.

## Interface
- `DATA_WIDTH`, default `core_pkg::DATA_WIDTH` (32): data bus width; 32 or 64 only.
- `ADDR_WIDTH`, default `core_pkg::ADDR_WIDTH` (32): address bus width.
- `DEPTH_WORDS`, default 1024: RAM depth in `DATA_WIDTH` words; power of two.
- `BASE_ADDR`, default 0: byte address of word 0; aligned to the RAM size.
- `WAIT_CYCLES`, default 0: extra cycles between grant and `rvalid_o`; 0..15.
- `clk_i` in 1: system clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_i` in 1: address-phase request.
- `gnt_o` out 1: address-phase grant.
- `addr_i` in `ADDR_WIDTH`: byte address; low `ADDR_OFFSET_WIDTH` bits ignored.
- `we_i` in 1: 1 write, 0 read.
- `wdata_i` in `DATA_WIDTH`: write data, lane-aligned.
- `be_i` in `DATA_WIDTH/8`: byte enables (writes only; ignored on reads).
- `rvalid_o` out 1: response valid, one-cycle pulse per transaction.
- `rdata_o` out `DATA_WIDTH`: read data; 0 when `rvalid_o`=0, on writes, or on error.
- `err_o` out 1: out-of-range access; asserted only with `rvalid_o`.

## Operation
- One outstanding transaction maximum. FSM states: `IDLE`, `WAIT`, `RESP`.
- `gnt_o = req_i` in `IDLE` and `RESP`; 0 in `WAIT`. Combinational from `req_i` and state.
- On grant (`req_i & gnt_o`): capture addr/we/wdata/be and range check. Next state is `RESP` if `WAIT_CYCLES`=0, else `WAIT` with counter loaded to `WAIT_CYCLES`.
- `WAIT`: counter decrements each cycle; at counter==1, next state is `RESP`.
- `RESP`: `rvalid_o`=1 for exactly one cycle. Next state is `IDLE`, or a new capture (to `RESP`/`WAIT`) if granted in the same cycle.
- In range: word index = (addr − `BASE_ADDR`) >> `ADDR_OFFSET_WIDTH`, compared against `DEPTH_WORDS`.
- Out of range: no RAM write, `err_o`=1, `rdata_o`=0.
- Write commit happens on the clock edge entering `RESP`. Only bytes with `be`=1 are modified; `be`=0 changes nothing.
- Read data is sampled on the same edge entering `RESP`. A read granted in the `RESP` cycle of a write to the same word returns the new data.

## Timing
- Reset values: state `IDLE`, counter 0, `rvalid_o`=0, `err_o`=0, `rdata_o`=0. `gnt_o` follows `req_i` from the first cycle after reset. RAM contents are not reset.
- Latency: `rvalid_o` rises `WAIT_CYCLES`+1 cycles after the grant cycle.
- Throughput: one transaction per cycle at `WAIT_CYCLES`=0; one per `WAIT_CYCLES`+1 cycles otherwise.
- Reset asserted in `WAIT`: the transaction is dropped, no write is committed, and no `rvalid_o` is produced.
- Reset asserted in `RESP`: the write is already committed; `rvalid_o` clears asynchronously.
- Request attributes are sampled only at grant; changes on `req_i`/`addr_i` during `WAIT` are ignored.

## Structure
- `core_pkg` adds a state typedef `obi_rsp_state_e` (`IDLE`/`WAIT`/`RESP`) and `OBI_MAX_WAIT` = 15. It reuses the existing `ADDR_OFFSET_WIDTH` and `BYTE_LENGTH`.
- Sub-module `sram_be`: single-port synchronous RAM, `DEPTH_WORDS` x `DATA_WIDTH`, per-byte write enable, registered read. It is instantiated once.
- The responder itself holds the FSM, wait counter, request capture, range check, and response mux.

## Test plan
- `WAIT_CYCLES`=0: write 0xDEADBEEF to 0x10 with `be`=0xF, then read 0x10 in the next cycle. Expect `gnt_o` both cycles, `rvalid_o` back-to-back, and second `rdata_o`=0xDEADBEEF.
- Byte mask: word at 0x20 preset to 0x11223344; write `wdata`=0x0000AA00 with `be`=0x2. A read then returns 0x1122AA44.
- `WAIT_CYCLES`=3: read 0x10 granted at cycle N. Expect `gnt_o`=0 for N+1..N+3, `rvalid_o` only at N+4, and a request held during the wait granted at N+4.
- Out of range with `DEPTH_WORDS`=1024: write to 0x1000 then read 0x1000. Both respond with `err_o`=1 and `rdata_o`=0; the RAM image is unchanged.
- Reset mid-op with `WAIT_CYCLES`=2: write 0x55 to 0x30, pulse `rst_i` during `WAIT`. Expect no `rvalid_o`, and a read of 0x30 returns its old value.
- Reset values: hold `rst_i` with random inputs. Expect `rvalid_o`=0, `err_o`=0, `rdata_o`=0 throughout.
